// File: rtl/pulse_compress_if.sv
// Pulse compressor bundle: raw pulse input, error clear, strobes and status.
// master drives signal/err_clr; slave (the compressor) drives the rest.
interface pulse_compress_if #(
  parameter int CNT_W = 8
);
  logic             signal;
  logic             err_clr;
  logic             pulse_out;
  logic [CNT_W-1:0] pulse_width;
  logic             width_valid;
  logic             err_stuck;
  logic [7:0]       glitch_cnt;
  logic             busy;

  modport master (
    output signal, err_clr,
    input  pulse_out, pulse_width, width_valid,
    input  err_stuck, glitch_cnt, busy
  );

  modport slave (
    input  signal, err_clr,
    output pulse_out, pulse_width, width_valid,
    output err_stuck, glitch_cnt, busy
  );
endinterface

// File: rtl/pulse_compress.sv
// Qualifies and measures stretched, glitchy pulses: sync, min-width filter,
// one-cycle strobe, width report, stuck detect, holdoff. Ports: clk, rst_n, bus.
module pulse_compress #(
  parameter int    MIN_WIDTH = 3,
  parameter int    MAX_WIDTH = 64,
  parameter int    HOLDOFF   = 4,
  parameter int    CNT_W     = 8,
  parameter string POLARITY  = "HIGH"
) (
  input logic             clk,
  input logic             rst_n,
  pulse_compress_if.slave bus
);

  localparam bit ACT_HI = (POLARITY == "HIGH");
  localparam logic IDLE_LVL = ACT_HI ? 1'b0 : 1'b1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MIN1 = CNT_W'(MIN_WIDTH - 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_WIDTH);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUAL,
    S_ACTIVE,
    S_STUCK,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic [HW-1:0]    r_hcnt;
  logic             r_pulse;
  logic             r_wv;
  logic [CNT_W-1:0] r_pw;
  logic             r_err;
  logic [7:0]       r_glitch;
  logic             r_busy;
  logic             w_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= IDLE_LVL;
      r_s2 <= IDLE_LVL;
    end else begin
      r_s1 <= bus.signal;
      r_s2 <= r_s1;
    end
  end

  assign w_act = ACT_HI ? r_s2 : ~r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hcnt   <= '0;
      r_pulse  <= 1'b0;
      r_wv     <= 1'b0;
      r_pw     <= '0;
      r_err    <= 1'b0;
      r_glitch <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      r_wv    <= 1'b0;
      // a stuck detect in the same cycle overrides this below
      if (bus.err_clr) r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_act) begin
            r_cnt   <= C_ONE;
            r_state <= S_QUAL;
            r_busy  <= 1'b1;
          end else begin
            r_cnt <= '0;
          end
        end
        S_QUAL: begin
          if (!w_act) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (r_glitch != 8'hFF) r_glitch <= r_glitch + 8'd1;
          end else if (r_cnt == C_MIN1) begin
            r_cnt   <= r_cnt + C_ONE;
            r_pulse <= 1'b1;
            r_state <= S_ACTIVE;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_ACTIVE: begin
          if (!w_act) begin
            r_pw    <= r_cnt;
            r_wv    <= 1'b1;
            r_hcnt  <= '0;
            r_state <= S_HOLD;
          end else if (r_cnt == C_MAX) begin
            r_err   <= 1'b1;
            r_state <= S_STUCK;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_STUCK: begin
          if (!w_act) begin
            r_hcnt  <= '0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_hcnt == H_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hcnt <= r_hcnt + H_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse_out   = r_pulse;
  assign bus.width_valid = r_wv;
  assign bus.pulse_width = r_pw;
  assign bus.err_stuck   = r_err;
  assign bus.glitch_cnt  = r_glitch;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_pulse_compress.sv
// Directed bench for pulse_compress: HIGH and LOW polarity instances,
// MIN_WIDTH=3, MAX_WIDTH=10, HOLDOFF=4.
module tb_pulse_compress;

  logic clk;
  logic rst_n;

  pulse_compress_if #(.CNT_W(8)) a_if ();
  pulse_compress_if #(.CNT_W(8)) b_if ();

  pulse_compress #(
    .MIN_WIDTH(3), .MAX_WIDTH(10), .HOLDOFF(4),
    .CNT_W(8), .POLARITY("HIGH")
  ) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
  );

  pulse_compress #(
    .MIN_WIDTH(3), .MAX_WIDTH(10), .HOLDOFF(4),
    .CNT_W(8), .POLARITY("LOW")
  ) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  int pcount, pedge, wcount, wedge, pw_last;
  int overlap, busy_fall;
  bit seen_busy;
  logic err_at [64];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // pat[k] = active level presented before edge k
  task automatic drive(input logic [63:0] pat, input int n,
                       input bit sel, input logic clr);
    logic po, wv, bz;
    pcount = 0; pedge = -1; wcount = 0; wedge = -1;
    pw_last = -1; overlap = 0; busy_fall = -1; seen_busy = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (sel) b_if.signal = ~pat[k];
      else     a_if.signal = pat[k];
      a_if.err_clr = clr;
      @(posedge clk);
      #1;
      po = sel ? b_if.pulse_out : a_if.pulse_out;
      wv = sel ? b_if.width_valid : a_if.width_valid;
      bz = sel ? b_if.busy : a_if.busy;
      if (k < 64) err_at[k] = a_if.err_stuck;
      if (po) begin pcount++; pedge = k; end
      if (wv) begin
        wcount++; wedge = k;
        pw_last = sel ? int'(b_if.pulse_width) : int'(a_if.pulse_width);
      end
      if (po && wv) overlap++;
      if (bz) seen_busy = 1;
      else if (seen_busy && busy_fall < 0) busy_fall = k;
    end
    @(negedge clk);
    if (sel) b_if.signal = 1'b1;
    else     a_if.signal = 1'b0;
    a_if.err_clr = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    a_if.signal = 1'b0;
    a_if.err_clr = 1'b0;
    b_if.signal = 1'b1;
    b_if.err_clr = 1'b0;
    rst_n = 1'b0;
    #23;
    chk("reset_outs_a", int'({a_if.pulse_out, a_if.width_valid,
        a_if.pulse_width, a_if.err_stuck, a_if.glitch_cnt, a_if.busy}), 0);
    chk("reset_outs_b", int'({b_if.pulse_out, b_if.width_valid,
        b_if.pulse_width, b_if.err_stuck, b_if.glitch_cnt, b_if.busy}), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 5-sample pulse
    drive(64'h1F, 16, 0, 0);
    chk("p5_pcount", pcount, 1);
    chk("p5_pedge", pedge, 4);
    chk("p5_wcount", wcount, 1);
    chk("p5_wedge", wedge, 7);
    chk("p5_width", pw_last, 5);
    chk("p5_busy_fall", busy_fall, 11);
    chk("p5_overlap", overlap, 0);
    chk("p5_glitch", int'(a_if.glitch_cnt), 0);

    // 2-sample glitch
    drive(64'h3, 8, 0, 0);
    chk("g2_pcount", pcount, 0);
    chk("g2_wcount", wcount, 0);
    chk("g2_glitch", int'(a_if.glitch_cnt), 1);

    // two 5-sample pulses with one idle sample between
    drive(64'h7DF, 20, 0, 0);
    chk("b2b_pcount", pcount, 1);
    chk("b2b_wcount", wcount, 1);
    chk("b2b_width", pw_last, 5);
    chk("b2b_glitch", int'(a_if.glitch_cnt), 2);

    // 15-sample stuck pulse
    drive(64'h7FFF, 24, 0, 0);
    chk("s15_pcount", pcount, 1);
    chk("s15_wcount", wcount, 0);
    chk("s15_err_e11", int'(err_at[11]), 0);
    chk("s15_err_e12", int'(err_at[12]), 1);
    chk("s15_err_end", int'(a_if.err_stuck), 1);
    chk("s15_width_kept", int'(a_if.pulse_width), 5);
    @(negedge clk);
    a_if.err_clr = 1'b1;
    @(negedge clk);
    a_if.err_clr = 1'b0;
    chk("errclr", int'(a_if.err_stuck), 0);

    // exactly MAX_WIDTH is legal
    drive(64'h3FF, 20, 0, 0);
    chk("m10_wcount", wcount, 1);
    chk("m10_wedge", wedge, 12);
    chk("m10_width", pw_last, 10);
    chk("m10_err", int'(a_if.err_stuck), 0);

    // MAX_WIDTH+1 is stuck; err_clr held high: set wins, then clears
    drive(64'h7FF, 20, 0, 1);
    chk("m11_pcount", pcount, 1);
    chk("m11_wcount", wcount, 0);
    chk("m11_err_e12", int'(err_at[12]), 1);
    chk("m11_err_e13", int'(err_at[13]), 0);
    chk("m11_width_kept", int'(a_if.pulse_width), 10);

    // LOW polarity, 4 active samples
    drive(64'hF, 16, 1, 0);
    chk("low_pcount", pcount, 1);
    chk("low_pedge", pedge, 4);
    chk("low_wedge", wedge, 6);
    chk("low_width", pw_last, 4);
    chk("low_busy_fall", busy_fall, 10);
    chk("low_overlap", overlap, 0);

    // glitch counter saturation
    for (int i = 0; i < 300; i++) drive(64'h3, 6, 0, 0);
    chk("glitch_sat", int'(a_if.glitch_cnt), 255);

    // reset during ACTIVE with error flag set
    drive(64'hFFF, 20, 0, 0);
    chk("pre_rst_err", int'(a_if.err_stuck), 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a_if.signal = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", int'(a_if.busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_outs_a", int'({a_if.pulse_out, a_if.width_valid,
        a_if.pulse_width, a_if.err_stuck, a_if.glitch_cnt, a_if.busy}), 0);
    chk("rst_outs_b", int'({b_if.pulse_out, b_if.width_valid,
        b_if.pulse_width, b_if.err_stuck, b_if.glitch_cnt, b_if.busy}), 0);
    a_if.signal = 1'b0;
    #2;
    rst_n = 1'b1;
    drive(64'h0, 10, 0, 0);
    chk("post_rst_pcount", pcount, 0);
    chk("post_rst_wcount", wcount, 0);
    chk("post_rst_busy", int'(seen_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_compress.md
PULSE_COMPRESS -- requirements
Module: pulse_compress

Interface
REQ-001 Parameter MIN_WIDTH, default 3: consecutive active samples needed to qualify a pulse; SHALL be >= 2.
REQ-002 Parameter MAX_WIDTH, default 64: longest legal pulse in active samples; SHALL be > MIN_WIDTH and < 2^CNT_W.
REQ-003 Parameter HOLDOFF, default 4: dead cycles after each pulse end; SHALL be >= 1.
REQ-004 Parameter CNT_W, default 8: width of the width-measurement counter and of pulse_width.
REQ-005 Parameter POLARITY, default "HIGH": "HIGH" means signal active = 1; any other value means active = 0.
REQ-006 Reset and clock are decided: one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  sole clock; all flops rising-edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 signal  input  1  asynchronous stretched pulse, possibly glitchy.
REQ-010 err_clr  input  1  single-cycle clear of err_stuck.
REQ-011 pulse_out  output  1  one-cycle active-high strobe per qualified pulse.
REQ-012 pulse_width  output  CNT_W  measured active-sample count of the last completed pulse.
REQ-013 width_valid  output  1  one-cycle strobe; pulse_width is updated in the same cycle.
REQ-014 err_stuck  output  1  sticky flag set when a pulse exceeds MAX_WIDTH.
REQ-015 glitch_cnt  output  8  saturating count of rejected (sub-MIN_WIDTH) pulses.
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 signal SHALL pass through a 2-flop synchronizer; act = sync output, inverted when POLARITY != "HIGH".
REQ-018 The FSM SHALL have states IDLE, QUAL, ACTIVE, STUCK, HOLDOFF; cnt is CNT_W bits and hcnt holds 0..HOLDOFF-1.
REQ-019 IDLE: act=1 -> cnt=1, go QUAL; act=0 -> stay, cnt=0.
REQ-020 QUAL, act=0: go IDLE and increment glitch_cnt, saturating at 255.
REQ-021 QUAL, act=1, cnt==MIN_WIDTH-1: cnt=MIN_WIDTH, pulse_out=1 for exactly the next cycle, go ACTIVE.
REQ-022 QUAL, act=1, cnt<MIN_WIDTH-1: cnt+1, stay.
REQ-023 ACTIVE, act=0: pulse_width=cnt, width_valid=1 for one cycle, hcnt=0, go HOLDOFF.
REQ-024 ACTIVE, act=1, cnt==MAX_WIDTH: err_stuck=1, go STUCK; otherwise cnt+1, stay.
REQ-025 STUCK: act=0 -> hcnt=0, go HOLDOFF; pulse_width and width_valid are untouched.
REQ-026 HOLDOFF: act is ignored; hcnt increments; hcnt==HOLDOFF-1 -> go IDLE.
REQ-027 Latency: signal first sampled active at edge 0 -> pulse_out high after edge MIN_WIDTH+1.
REQ-028 Pulse of n samples (MIN_WIDTH<=n<=MAX_WIDTH) -> width_valid after edge n+2, pulse_width=n.
REQ-029 err_clr clears err_stuck; when set and clear coincide in one cycle, set wins.
REQ-030 pulse_out and width_valid SHALL never be high in the same cycle; all outputs are registered.
REQ-031 A pulse active at reset release is handled as a new pulse from its first synchronized sample.

Reset
REQ-032 On rst_n=0 all of these SHALL clear immediately: state=IDLE, cnt=0, hcnt=0, synchronizer flops = inactive level (0 if "HIGH", 1 otherwise).
REQ-033 On rst_n=0 all outputs SHALL clear immediately: pulse_out=0, width_valid=0, pulse_width=0, err_stuck=0, glitch_cnt=0, busy=0.
REQ-034 Reset asserted mid-pulse (any state) SHALL abort without emitting pulse_out or width_valid.

Verification (MIN_WIDTH=3, MAX_WIDTH=10, HOLDOFF=4, POLARITY="HIGH")
REQ-035 signal high 5 cycles -> one pulse_out after edge 4; width_valid after edge 7 with pulse_width=5; busy drops 4 cycles later.
REQ-036 signal high 2 cycles -> no pulse_out, no width_valid, glitch_cnt 0->1; 300 such glitches -> glitch_cnt=255.
REQ-037 signal high 15 cycles -> pulse_out once, err_stuck=1, no width_valid; err_clr -> err_stuck=0.
REQ-038 Second 5-cycle pulse starting 1 cycle after the first ends -> second pulse is not double-counted while in HOLDOFF; its remaining active samples are handled per REQ-019..REQ-024.
REQ-039 POLARITY="LOW", signal low 4 cycles -> pulse_out once, pulse_width=4.
REQ-040 rst_n asserted during ACTIVE -> all outputs 0 at once; after release with signal idle, no strobes.
